dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
Sits directly downstream of the single-cycle cpu's load/store path, between the cpu and a multi-cycle data memory with a req/ack handshake. It turns a one-cycle load_word/store_word request into a registered memory transaction and stalls the cpu until the transaction completes. It also flags misaligned or illegal accesses and memory timeouts as a fault that the cpu routes to its panic path.

Parameters:
DATA_WIDTH, 32, width of the data buses.
ADDR_WIDTH, 32, width of the address buses.
TIMEOUT_CYCLES, 16, maximum number of REQ cycles without mem_ack before a fault; must be >= 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserts when 0).
cpu_load  input  1  load_word request from control.
cpu_store  input  1  store_word request from control.
cpu_address  input  ADDR_WIDTH  byte address (register_b data).
cpu_wdata  input  DATA_WIDTH  store data (register_d data).
cpu_rdata  output  DATA_WIDTH  load result; valid in the DONE cycle.
cpu_stall  output  1  combinational; holds the PC and register write while high.
cpu_fault  output  1  one-cycle fault pulse to the panic logic.
mem_req  output  1  registered; request to memory.
mem_we  output  1  registered; 1 = write, 0 = read.
mem_addr  output  ADDR_WIDTH  registered word-aligned address.
mem_wdata  output  DATA_WIDTH  registered write data.
mem_ack  input  1  memory completion, sampled on the rising edge.
mem_rdata  input  DATA_WIDTH  read data, valid while mem_ack = 1.

Behaviour:
- States: IDLE, REQ, DONE, FAULT.
- Reset (reset = 0, asynchronous):
  - state = IDLE; mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata, cpu_fault and the timeout counter are all 0.
  - A reset in the middle of a transaction drops mem_req immediately. A later mem_ack is ignored.
- Request legality in IDLE:
  - illegal when cpu_address[1:0] != 0, or when cpu_load and cpu_store are both 1.
  - valid when exactly one of cpu_load/cpu_store is 1 and the access is legal.
- IDLE:
  - Valid request: cpu_stall = 1 in the same cycle. On the edge, latch the address and wdata, set mem_we = cpu_store and mem_req = 1, clear the counter, and go to REQ.
  - Illegal request: cpu_stall = 0 and cpu_fault = 1 in that same cycle (combinational). No memory access; stay in IDLE.
  - mem_ack while in IDLE is ignored.
- REQ:
  - cpu_stall = 1; mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - mem_ack = 1: on the edge, capture mem_rdata into cpu_rdata (reads only; writes leave cpu_rdata unchanged), set mem_req = 0, go to DONE.
  - No ack: the counter increments. If counter == TIMEOUT_CYCLES-1 and no ack, set mem_req = 0, clear cpu_rdata to 0, and go to FAULT.
  - If ack and timeout occur in the same cycle, the ack wins.
- DONE:
  - cpu_stall = 0, so the cpu commits the register write or advances the PC at this edge.
  - No new request is accepted in DONE; always go to IDLE.
- FAULT:
  - cpu_stall = 0, cpu_fault = 1 (registered, one cycle); go to IDLE.
- Latency:
  - A read with ack in the first REQ cycle occupies 3 cycles (IDLE-request, REQ, DONE).
  - Each extra wait cycle adds 1 cycle.
- cpu_rdata holds its last value outside DONE.

Decomposition:
- Shared package: the state encoding (2-bit IDLE = 0, REQ = 1, DONE = 2, FAULT = 3) and a constant for the word-alignment mask.
- One natural sub-module, dmem_timeout_counter: a clog2(TIMEOUT_CYCLES)-bit counter with clear/enable inputs and a terminal-count output.
- The FSM and datapath registers stay in the top module.

Test Plan:
1. Load, address 0x100, memory returns 0xDEADBEEF with ack on the 3rd REQ cycle -> cpu_stall high for 4 cycles, DONE in cycle 5 with cpu_rdata = 0xDEADBEEF, mem_we = 0 throughout.
2. Store, address 0x40, wdata 0x12345678, ack in the first REQ cycle -> mem_req = 1, mem_we = 1, mem_addr = 0x40, mem_wdata = 0x12345678 for 1 cycle, DONE in cycle 3, cpu_rdata unchanged.
3. Load at address 0x102 -> cpu_fault = 1 and cpu_stall = 0 in the same cycle, mem_req never rises.
4. cpu_load = cpu_store = 1 at address 0x8 -> same-cycle fault, no memory access.
5. Load with no ack, TIMEOUT_CYCLES = 16 -> 16 REQ cycles, then FAULT with cpu_fault = 1, cpu_rdata = 0, mem_req = 0. An ack injected afterwards is ignored.
6. reset driven low in the 2nd REQ cycle -> all outputs 0 asynchronously. After release, a load at 0x0 with immediate ack completes normally in 3 cycles.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// dmem_access_unit_pkg
// Shared definitions for the data-memory access unit: FSM state encoding,
// the word-alignment mask and a small alignment helper.
// -----------------------------------------------------------------------------
package dmem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } dmem_state_t;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_timeout_counter.sv
// -----------------------------------------------------------------------------
// dmem_timeout_counter
// Counts REQ cycles spent waiting for the memory acknowledge.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear (has priority over en)
//   en     : increment by one
//   tc     : terminal count, high while count == TIMEOUT_CYCLES-1
// TIMEOUT_CYCLES must be >= 2.
// -----------------------------------------------------------------------------
module dmem_timeout_counter #(
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int CNT_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
// Converts a one-cycle load_word/store_word request from the single-cycle cpu
// into a registered req/ack transaction to a multi-cycle data memory, stalls
// the cpu until it completes, and raises a fault for misaligned/ambiguous
// requests and for memory timeouts.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   cpu_load     load_word request
//   cpu_store    store_word request
//   cpu_address  byte address
//   cpu_wdata    store data
//   cpu_rdata    load result, valid in the DONE cycle, held otherwise
//   cpu_stall    combinational stall (PC / register write hold)
//   cpu_fault    fault pulse to the panic logic
//   mem_req      registered memory request
//   mem_we       registered write enable (1 = write)
//   mem_addr     registered word-aligned address
//   mem_wdata    registered write data
//   mem_ack      memory completion
//   mem_rdata    memory read data, valid with mem_ack
// -----------------------------------------------------------------------------
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_load,
  input  logic                  cpu_store,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  cpu_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  dmem_state_t state, state_next;

  logic req_any;
  logic req_illegal;
  logic req_valid;
  logic timeout;

  // Request decode: both strobes at once or a non-word address is illegal.
  assign req_any     = cpu_load | cpu_store;
  assign req_illegal = req_any &
                       ((cpu_load & cpu_store) | is_misaligned(cpu_address[1:0]));
  assign req_valid   = req_any & ~req_illegal;

  // The counter sits at zero outside REQ, so entering REQ always starts a
  // fresh wait window; it only advances on cycles without an acknowledge.
  dmem_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (reset),
    .clr   (state != ST_REQ),
    .en    ((state == ST_REQ) && !mem_ack),
    .tc    (timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. An acknowledge in the timeout cycle still completes.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (req_valid) state_next = ST_REQ;
      ST_REQ: begin
        if (mem_ack)      state_next = ST_DONE;
        else if (timeout) state_next = ST_FAULT;
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_FAULT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output logic. Gated by reset so every output reads 0 while reset is
  // asserted, even if the cpu is still presenting a request.
  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned (which would infer a latch).
  always_comb begin
    cpu_stall = 1'b0;
    cpu_fault = 1'b0;
    if (reset) begin
      case (state)
        ST_IDLE: begin
          cpu_stall = req_valid;
          cpu_fault = req_illegal;
        end
        ST_REQ:   cpu_stall = 1'b1;
        ST_FAULT: cpu_fault = 1'b1;
        default:  ;
      endcase
    end
  end

  // Datapath registers: memory-side request and the load result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_store;
            mem_addr  <= cpu_address & ~ADDR_WIDTH'(WORD_ALIGN_MASK);
            mem_wdata <= cpu_wdata;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) cpu_rdata <= mem_rdata;
          end else if (timeout) begin
            mem_req   <= 1'b0;
            cpu_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_unit
// Self-checking bench for dmem_access_unit: a directed vector table, hand
// sequences for reset-in-flight and post-timeout acknowledge, and randomized
// transactions checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_dmem_access_unit;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk;
  logic          reset;
  logic          cpu_load;
  logic          cpu_store;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          cpu_fault;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  dmem_access_unit #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_load    (cpu_load),
    .cpu_store   (cpu_store),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .cpu_fault   (cpu_fault),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One transaction: cpu request, memory behaviour and expected outcome.
  // ack_at = n acknowledges in the n-th REQ cycle; 0 never acknowledges.
  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ack_at;
    bit          exp_comb_fault;
    bit          exp_reg_fault;
    int          exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          stall_cycles;
    int          req_cycles;
    bit          comb_fault;
    bit          reg_fault;
    bit          finished;
    logic [31:0] rdata;
    logic        req_at_end;
    logic        req_after;
  } res_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                              input bit ec, input bit er, input int es, input logic [31:0] erd);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.wd = wd; v.rd = rd; v.ack_at = ack_at;
    v.exp_comb_fault = ec; v.exp_reg_fault = er; v.exp_stall = es; v.exp_rdata = erd;
    return v;
  endfunction

  // Transaction-level reference: outcome derived from the access rules only.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_rdata);
    vec_t e;
    bit   has_req;
    bit   illegal;
    e       = v;
    has_req = v.ld || v.st;
    illegal = has_req && ((v.ld && v.st) || (v.addr % 4 != 0));
    e.exp_comb_fault = 1'b0;
    e.exp_reg_fault  = 1'b0;
    e.exp_stall      = 0;
    e.exp_rdata      = prev_rdata;
    if (illegal) begin
      e.exp_comb_fault = 1'b1;
    end else if (has_req) begin
      if (v.ack_at >= 1 && v.ack_at <= TO) begin
        e.exp_stall = v.ack_at + 1;
        if (v.ld) e.exp_rdata = v.rd;
      end else begin
        e.exp_stall     = TO + 1;
        e.exp_reg_fault = 1'b1;
        e.exp_rdata     = 32'h0;
      end
    end
    return e;
  endfunction

  // Drives one transaction, starting at posedge+1; plays the memory and
  // returns at posedge+1 of the cycle after the outcome cycle.
  task automatic run_txn(input vec_t v, output res_t r);
    int req_idx;
    int cyc;
    req_idx = 0;
    cyc     = 0;
    r.stall_cycles = 0; r.req_cycles = 0; r.comb_fault = 1'b0; r.reg_fault = 1'b0;
    r.finished = 1'b0; r.rdata = '0; r.req_at_end = 1'b0; r.req_after = 1'b0;
    cpu_load    = v.ld;
    cpu_store   = v.st;
    cpu_address = v.addr;
    cpu_wdata   = v.wd;
    while (!r.finished && cyc < 64) begin
      if (mem_req === 1'b1) begin
        req_idx++;
        r.req_cycles++;
        mem_ack   = (req_idx == v.ack_at);
        mem_rdata = mem_ack ? v.rd : $urandom();
        check("req_hold_we", mem_we, v.st);
        check("req_hold_addr", mem_addr, v.addr);
        check("req_hold_wdata", mem_wdata, v.wd);
      end else begin
        // Stray acknowledges outside REQ must be ignored.
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom();
      end
      #3;
      cyc++;
      if (cpu_stall === 1'b1) r.stall_cycles++;
      if (cpu_fault === 1'b1) begin
        if (cyc == 1) r.comb_fault = 1'b1;
        else          r.reg_fault  = 1'b1;
        r.finished = 1'b1;
      end else if (cpu_stall !== 1'b1) begin
        r.finished = 1'b1;
      end
      if (r.finished) begin
        r.rdata      = cpu_rdata;
        r.req_at_end = mem_req;
      end
      @(posedge clk);
      #1;
    end
    cpu_load  = 1'b0;
    cpu_store = 1'b0;
    mem_ack   = 1'b0;
    r.req_after = mem_req;
  endtask

  task automatic apply(input string tag, input vec_t v);
    res_t r;
    run_txn(v, r);
    check($sformatf("%s.finished", tag), r.finished, 1'b1);
    check($sformatf("%s.comb_fault", tag), r.comb_fault, v.exp_comb_fault);
    check($sformatf("%s.reg_fault", tag), r.reg_fault, v.exp_reg_fault);
    check($sformatf("%s.stall_cycles", tag), r.stall_cycles, v.exp_stall);
    check($sformatf("%s.req_cycles", tag), r.req_cycles,
          (v.exp_stall > 0) ? v.exp_stall - 1 : 0);
    check($sformatf("%s.rdata", tag), r.rdata, v.exp_rdata);
    check($sformatf("%s.req_at_end", tag), r.req_at_end, 1'b0);
    check($sformatf("%s.req_after", tag), r.req_after, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s.mem_req", tag), mem_req, 1'b0);
    check($sformatf("%s.mem_we", tag), mem_we, 1'b0);
    check($sformatf("%s.mem_addr", tag), mem_addr, 32'h0);
    check($sformatf("%s.mem_wdata", tag), mem_wdata, 32'h0);
    check($sformatf("%s.cpu_rdata", tag), cpu_rdata, 32'h0);
    check($sformatf("%s.cpu_fault", tag), cpu_fault, 1'b0);
    check($sformatf("%s.cpu_stall", tag), cpu_stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "tb watchdog expired");
  end

  initial begin
    vec_t        vecs[10];
    vec_t        v;
    logic [31:0] model_rdata;

    reset       = 1'b0;
    cpu_load    = 1'b0;
    cpu_store   = 1'b0;
    cpu_address = '0;
    cpu_wdata   = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;

    // Directed table: ld, st, addr, wdata, mem rdata, ack_at,
    //                 comb fault, reg fault, stall cycles, cpu_rdata after.
    vecs[0] = mk(1, 0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3,  0, 0, 4,  32'hDEAD_BEEF);
    vecs[1] = mk(0, 1, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFF, 1,  0, 0, 2,  32'hDEAD_BEEF);
    vecs[2] = mk(1, 0, 32'h0000_0102, 32'h0,         32'h1111_1111, 1,  1, 0, 0,  32'hDEAD_BEEF);
    vecs[3] = mk(1, 1, 32'h0000_0008, 32'h0,         32'h2222_2222, 1,  1, 0, 0,  32'hDEAD_BEEF);
    vecs[4] = mk(0, 0, 32'h0000_0010, 32'h0,         32'h3333_3333, 1,  0, 0, 0,  32'hDEAD_BEEF);
    vecs[5] = mk(0, 1, 32'h0000_0041, 32'hAAAA_0000, 32'h4444_4444, 1,  1, 0, 0,  32'hDEAD_BEEF);
    vecs[6] = mk(1, 0, 32'h0000_0200, 32'h0,         32'h0BAD_F00D, 16, 0, 0, 17, 32'h0BAD_F00D);
    vecs[7] = mk(1, 0, 32'h0000_0300, 32'h0,         32'h5555_5555, 0,  0, 1, 17, 32'h0);
    vecs[8] = mk(1, 0, 32'h0000_0004, 32'h0,         32'h55AA_55AA, 2,  0, 0, 3,  32'h55AA_55AA);
    vecs[9] = mk(0, 1, 32'hFFFF_FFFC, 32'hC0DE_0001, 32'h6666_6666, 5,  0, 0, 6,  32'h55AA_55AA);

    // Reset state.
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted in the 2nd REQ cycle of a store.
    cpu_store   = 1'b1;
    cpu_address = 32'h0000_0080;
    cpu_wdata   = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    check("rst_seq.req_cycle1", mem_req, 1'b1);
    @(posedge clk);
    #1;
    check("rst_seq.req_cycle2", mem_req, 1'b1);
    #1 reset = 1'b0;
    #1;
    check_all_zero("rst_seq.async");
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(posedge clk);
    #1;
    check_all_zero("rst_seq.held");
    cpu_store = 1'b0;
    mem_ack   = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    #3;
    check_all_zero("rst_seq.released");
    @(posedge clk);
    #1;
    apply("rst_seq.load0", mk(1, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 1, 0, 0, 2, 32'hCAFE_F00D));

    // Timeout followed by a late acknowledge that must be ignored.
    apply("late_ack.timeout", mk(1, 0, 32'h0000_0300, 32'h0, 32'h8888_8888, 0, 0, 1, 17, 32'h0));
    for (int i = 0; i < 2; i++) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'h9999_9999;
      #3;
      check($sformatf("late_ack.rdata%0d", i), cpu_rdata, 32'h0);
      check($sformatf("late_ack.req%0d", i), mem_req, 1'b0);
      check($sformatf("late_ack.stall%0d", i), cpu_stall, 1'b0);
      check($sformatf("late_ack.fault%0d", i), cpu_fault, 1'b0);
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;

    // Randomized transactions against the reference model.
    model_rdata = 32'h0;
    for (int n = 0; n < 60; n++) begin
      int op;
      op      = $urandom_range(0, 9);
      v.ld    = (op == 1) || (op >= 2 && op <= 5);
      v.st    = (op == 1) || (op >= 6);
      v.addr  = $urandom() & 32'hFFFF_FFFC;
      if ((v.ld || v.st) && $urandom_range(0, 4) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
      v.wd     = $urandom();
      v.rd     = $urandom();
      v.ack_at = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 2);
      v        = model(v, model_rdata);
      model_rdata = v.exp_rdata;
      apply($sformatf("rand%0d", n), v);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
